fp_normalize_pack: RTL

- Final stage of the single-precision add/subtract pipeline; the output counterpart of the unpack/compare front stage.
- Takes the raw signed-magnitude mantissa sum, the larger operand's biased exponent and guard/round/sticky bits from the add stage.
- Normalizes, rounds to nearest-even and repacks into an IEEE-754 32-bit word with status flags.
- Two internal register stages with a valid/ready handshake on both sides.

---
 rtl/fp_pkg.sv | 19 +
 rtl/fp_lzc24.sv | 20 ++
 rtl/fp_normalize_pack.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared widths, constants and flag bundle for the single-precision add/subtract pipeline.
package fp_pkg;

    localparam int unsigned EXP_W    = 8;
    localparam int unsigned FRAC_W   = 23;
    localparam int unsigned MAN_W    = FRAC_W + 1;
    localparam int unsigned EXP_BIAS = 127;
    localparam int unsigned EXP_MAX  = 255;

    localparam logic [31:0] QNAN    = 32'h7FC00000;
    localparam logic [31:0] POS_INF = 32'h7F800000;

    typedef struct packed {
        logic overflow;
        logic underflow;
        logic inexact;
    } fp_flags_t;

endpackage

// File: rtl/fp_lzc24.sv
// Combinational 24-bit leading-zero counter; count is 24 and zero is set for an all-zero input.
module fp_lzc24 (
    input  logic [23:0] d,
    output logic [4:0]  count,
    output logic        zero
);

    always_comb begin
        count = 5'd24;
        zero  = 1'b1;
        // Ascending scan: the last hit is the most significant set bit.
        for (int i = 0; i < 24; i++) begin
            if (d[i]) begin
                count = 5'(23 - i);
                zero  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/fp_normalize_pack.sv
// Normalize, round-to-nearest-even and pack stage of the FP add/subtract pipeline.
// Define FP_DENORM_EN to produce subnormal results instead of flushing tiny results to zero.
module fp_normalize_pack #(
    parameter int unsigned EXP_W  = 8,
    parameter int unsigned FRAC_W = 23
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sign,
    input  logic [EXP_W-1:0]        in_exp,
    input  logic [FRAC_W+1:0]       in_man,
    input  logic [2:0]              in_grs,
    input  logic                    in_nan,
    input  logic                    in_inf,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+FRAC_W:0]   result,
    output logic                    flag_overflow,
    output logic                    flag_underflow,
    output logic                    flag_inexact
);
    import fp_pkg::*;

    localparam int unsigned EW = EXP_W + 2;

    // Handshake: each stage loads when empty or when the stage after it loads.
    logic a_valid, b_valid, a_load, b_load;
    assign b_load    = !b_valid || out_ready;
    assign a_load    = !a_valid || b_load;
    assign in_ready  = a_load;
    assign out_valid = b_valid;

    // Stage A: normalize
    logic [4:0]          lz;
    logic                lz_zero;
    logic [25:0]         shl;
    logic [MAN_W-1:0]    n_man;
    logic                n_g, n_r, n_s, n_zero;
    logic signed [EW-1:0] n_exp;

    fp_lzc24 u_lzc (
        .d     (in_man[23:0]),
        .count (lz),
        .zero  (lz_zero)
    );

    always_comb begin
        shl   = '0;
        n_man = in_man[24:1];
        n_g   = in_man[0];
        n_r   = in_grs[2];
        n_s   = in_grs[1] | in_grs[0];
        n_exp = $signed({2'b00, in_exp}) + EW'(1);
        if (!in_man[24]) begin
            shl   = {in_man[23:0], in_grs[2:1]} << lz;
            n_man = shl[25:2];
            n_g   = shl[1];
            n_r   = shl[0];
            n_s   = in_grs[0];
            n_exp = $signed({2'b00, in_exp}) - $signed({{(EW-5){1'b0}}, lz});
        end
    end

    assign n_zero = !in_man[24] && lz_zero && (in_grs == 3'b000);

    logic                 a_sign, a_g, a_r, a_s, a_nan, a_inf, a_zero;
    logic [MAN_W-1:0]     a_man;
    logic signed [EW-1:0] a_exp;

    always_ff @(posedge clk) begin
        if (a_load && in_valid) begin
            a_sign <= in_sign;
            a_exp  <= n_exp;
            a_man  <= n_man;
            a_g    <= n_g;
            a_r    <= n_r;
            a_s    <= n_s;
            a_nan  <= in_nan;
            a_inf  <= in_inf;
            a_zero <= n_zero;
        end
    end

    // Stage B: round and pack
    logic                  rnd_inc, rnd_carry;
    logic [FRAC_W-1:0]     rnd_frac;
    logic signed [EW-1:0]  exp_r;
    logic [EXP_W+FRAC_W:0] b_res;
    fp_flags_t             b_flags, flags_q;

    assign rnd_inc              = a_g && (a_r || a_s || a_man[0]);
    assign {rnd_carry, rnd_frac} = {1'b0, a_man[FRAC_W-1:0]} + {{FRAC_W{1'b0}}, rnd_inc};
    assign exp_r                = a_exp + $signed({{(EW-1){1'b0}}, rnd_carry});

`ifdef FP_DENORM_EN
    logic signed [EW-1:0] dn_amt;
    logic [4:0]           dn_sh;
    logic [51:0]          dn_ext;
    logic [MAN_W-1:0]     dn_man, dn_sum;
    logic                 dn_g, dn_r, dn_s, dn_inc;

    assign dn_amt = EW'(1) - a_exp;
    assign dn_sh  = (dn_amt > EW'(25)) ? 5'd25 : dn_amt[4:0];
    assign dn_ext = {a_man, a_g, a_r, 26'b0} >> dn_sh;
    assign dn_man = dn_ext[51:28];
    assign dn_g   = dn_ext[27];
    assign dn_r   = dn_ext[26];
    assign dn_s   = a_s || (|dn_ext[25:0]);
    assign dn_inc = dn_g && (dn_r || dn_s || dn_man[0]);
    assign dn_sum = dn_man + {{(MAN_W-1){1'b0}}, dn_inc};
`endif

    always_comb begin
        b_res   = {a_sign, exp_r[EXP_W-1:0], rnd_frac};
        b_flags = '{overflow: 1'b0, underflow: 1'b0, inexact: a_g | a_r | a_s};
        if (a_nan) begin
            b_res   = QNAN;
            b_flags = '0;
        end else if (a_inf) begin
            b_res   = {a_sign, POS_INF[30:0]};
            b_flags = '0;
        end else if (a_zero) begin
            b_res   = {a_sign, 31'h0};
            b_flags = '0;
        end else if (a_exp <= EW'(0)) begin
`ifdef FP_DENORM_EN
            // Hidden-bit carry out of the subnormal lands in the exponent LSB.
            b_res   = {a_sign, 7'h00, dn_sum[23], dn_sum[22:0]};
            b_flags = '{overflow: 1'b0, underflow: 1'b1, inexact: dn_g | dn_r | dn_s};
`else
            b_res   = {a_sign, 31'h0};
            b_flags = '{overflow: 1'b0, underflow: 1'b1,
                        inexact: (|a_man) | a_g | a_r | a_s};
`endif
        end else if (exp_r >= $signed(EW'(EXP_MAX))) begin
            b_res   = {a_sign, POS_INF[30:0]};
            b_flags = '{overflow: 1'b1, underflow: 1'b0, inexact: 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_valid <= 1'b0;
            b_valid <= 1'b0;
            result  <= '0;
            flags_q <= '0;
        end else begin
            if (a_load) a_valid <= in_valid;
            if (b_load) b_valid <= a_valid;
            if (b_load && a_valid) begin
                result  <= b_res;
                flags_q <= b_flags;
            end
        end
    end

    assign flag_overflow  = flags_q.overflow;
    assign flag_underflow = flags_q.underflow;
    assign flag_inexact   = flags_q.inexact;

endmodule
